// File: rtl/signal_ctrl_pkg.sv
// signal_ctrl_pkg: shared phase encoding and lamp constants for the multiway signal controller.
package signal_ctrl_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2,
        WALK    = 2'd3
    } phase_e;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

endpackage

// File: rtl/multiway_signal_controller_arbiter.sv
// rr_demand_arbiter: combinational round-robin pick of the first set demand bit after last, wrapping.
module rr_demand_arbiter #(
    parameter int NUM_DIRS = 4,
    localparam int DW = $clog2(NUM_DIRS)
) (
    input  logic [NUM_DIRS-1:0] demand,
    input  logic [DW-1:0]       last,
    output logic                found,
    output logic [DW-1:0]       next_dir
);

    // Scan from farthest to nearest so the nearest candidate after last wins.
    always_comb begin
        next_dir = last;
        for (int k = NUM_DIRS; k >= 1; k--) begin
            if (demand[(int'(last) + k) % NUM_DIRS]) next_dir = DW'((int'(last) + k) % NUM_DIRS);
        end
    end

    assign found = |demand;

endmodule

// File: rtl/multiway_signal_controller.sv
// multiway_signal_controller: demand-driven round-robin N-way signal FSM with all-red clearance.
// Optional pedestrian walk phase compiled in with SIGNAL_CTRL_PED_EN.
module multiway_signal_controller
    import signal_ctrl_pkg::*;
#(
    parameter int NUM_DIRS   = 4,
    parameter int TIMER_W    = 8,
    parameter int GREEN_MIN  = 5,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2
`ifdef SIGNAL_CTRL_PED_EN
    , parameter int WALK_CYC = 4
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIRS-1:0]         car_req,
`ifdef SIGNAL_CTRL_PED_EN
    input  logic                        ped_req,
    output logic                        walk,
`endif
    output logic [3*NUM_DIRS-1:0]       light,
    output logic [$clog2(NUM_DIRS)-1:0] active_dir,
    output logic [1:0]                  phase
);

    localparam int DW = $clog2(NUM_DIRS);

    phase_e               phase_q, phase_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [DW-1:0]        dir_q, dir_d, next_dir;
    logic [NUM_DIRS-1:0]  demand_q, demand_d, dir_mask;
    logic                 found, competing;

    rr_demand_arbiter #(.NUM_DIRS(NUM_DIRS)) u_arb (
        .demand   (demand_q),
        .last     (dir_q),
        .found    (found),
        .next_dir (next_dir)
    );

    assign dir_mask = NUM_DIRS'(1) << dir_q;

`ifdef SIGNAL_CTRL_PED_EN
    logic ped_q, ped_d;
    assign competing = found | ped_q;
    assign walk      = phase_q == WALK;
`else
    assign competing = found;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q  <= ALL_RED;
            timer_q  <= TIMER_W'(ALLRED_CYC - 1);
            dir_q    <= DW'(NUM_DIRS - 1);
            demand_q <= '0;
`ifdef SIGNAL_CTRL_PED_EN
            ped_q    <= 1'b0;
`endif
        end else begin
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            dir_q    <= dir_d;
            demand_q <= demand_d;
`ifdef SIGNAL_CTRL_PED_EN
            ped_q    <= ped_d;
`endif
        end
    end

    always_comb begin
        phase_d  = phase_q;
        timer_d  = (timer_q == '0) ? timer_q : timer_q - 1'b1;
        dir_d    = dir_q;
        demand_d = demand_q | (car_req & ((phase_q == GREEN) ? ~dir_mask : '1));
`ifdef SIGNAL_CTRL_PED_EN
        ped_d    = ped_q | ped_req;
`endif
        case (phase_q)
            GREEN: begin
                if (timer_q == '0 && competing) begin
                    phase_d = YELLOW;
                    timer_d = TIMER_W'(YELLOW_CYC - 1);
                end
            end
            YELLOW: begin
                if (timer_q == '0) begin
                    phase_d = ALL_RED;
                    timer_d = TIMER_W'(ALLRED_CYC - 1);
                end
            end
            ALL_RED: begin
                if (timer_q == '0) begin
`ifdef SIGNAL_CTRL_PED_EN
                    if (ped_q) begin
                        phase_d = WALK;
                        timer_d = TIMER_W'(WALK_CYC - 1);
                        ped_d   = 1'b0;
                    end else
`endif
                    if (found) begin
                        phase_d            = GREEN;
                        timer_d            = TIMER_W'(GREEN_MIN - 1);
                        dir_d              = next_dir;
                        demand_d[next_dir] = 1'b0;
                    end
                end
            end
            default: begin
`ifdef SIGNAL_CTRL_PED_EN
                if (timer_q == '0) begin
                    phase_d = ALL_RED;
                    timer_d = TIMER_W'(ALLRED_CYC - 1);
                end
`else
                phase_d = ALL_RED;
                timer_d = TIMER_W'(ALLRED_CYC - 1);
`endif
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_DIRS; i++) begin
            light[3*i +: 3] = (DW'(i) != dir_q) ? LIGHT_RED :
                              (phase_q == GREEN) ? LIGHT_GRN :
                              (phase_q == YELLOW) ? LIGHT_YEL : LIGHT_RED;
        end
    end

    assign active_dir = dir_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_multiway_signal_controller.sv
// tb_multiway_signal_controller: directed scenarios plus randomized demand checked against a
// cycle-count reference model of the signal rules (default build, no pedestrian phase).
module tb_multiway_signal_controller;

    localparam int NUM_DIRS   = 4;
    localparam int GREEN_MIN  = 5;
    localparam int YELLOW_CYC = 3;
    localparam int ALLRED_CYC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  car_req = '0;
    logic [11:0] light;
    logic [1:0]  active_dir;
    logic [1:0]  phase;

    int checks = 0;
    int fails  = 0;

    int       m_ph, m_cnt, m_dir;
    bit [3:0] m_dem;

    multiway_signal_controller #(
        .NUM_DIRS(NUM_DIRS), .TIMER_W(8), .GREEN_MIN(GREEN_MIN),
        .YELLOW_CYC(YELLOW_CYC), .ALLRED_CYC(ALLRED_CYC)
    ) dut (
        .clk(clk), .reset(reset), .car_req(car_req),
        .light(light), .active_dir(active_dir), .phase(phase)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_reset();
        m_ph = 2; m_cnt = 1; m_dir = NUM_DIRS - 1; m_dem = '0;
    endtask

    // m_cnt is the 1-based count of cycles spent in the current phase.
    task automatic model_edge(input logic [3:0] req);
        bit [3:0] old;
        int dur, nd;
        old = m_dem;
        for (int i = 0; i < NUM_DIRS; i++)
            if (req[i] && !(m_ph == 0 && i == m_dir)) m_dem[i] = 1'b1;
        dur = (m_ph == 0) ? GREEN_MIN : (m_ph == 1) ? YELLOW_CYC : ALLRED_CYC;
        if (m_cnt < dur) m_cnt++;
        else if (m_ph == 1) begin m_ph = 2; m_cnt = 1; end
        else if (m_ph == 0 && (old & ~(4'b1 << m_dir)) != 0) begin m_ph = 1; m_cnt = 1; end
        else if (m_ph == 2 && old != 0) begin
            nd = m_dir;
            for (int k = 1; k <= NUM_DIRS; k++)
                if (old[(m_dir + k) % NUM_DIRS]) begin nd = (m_dir + k) % NUM_DIRS; break; end
            m_dir = nd; m_dem[nd] = 1'b0; m_ph = 0; m_cnt = 1;
        end
    endtask

    function automatic logic [11:0] m_light();
        logic [11:0] l;
        for (int i = 0; i < NUM_DIRS; i++)
            l[3*i +: 3] = (i != m_dir) ? 3'b100 : (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        return l;
    endfunction

    task automatic step(input logic [3:0] req);
        car_req = req;
        @(posedge clk);
        model_edge(req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        car_req = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        car_req = '0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (light !== 12'h924) begin fails++; $display("FAIL reset_light: got %h expected 924", light); end
        checks++; if (phase !== 2'd2) begin fails++; $display("FAIL reset_phase: got %0d expected 2", phase); end
        checks++; if (active_dir !== 2'd3) begin fails++; $display("FAIL reset_dir: got %0d expected 3", active_dir); end
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_idle();
        for (int c = 0; c < 50; c++) begin
            step(4'b0000);
            checks++; if (light !== 12'h924 || phase !== 2'd2) begin
                fails++; $display("FAIL idle c%0d: got light %h phase %0d expected 924 phase 2", c, light, phase);
            end
        end
    endtask

    task automatic test_single_pulse();
        for (int c = 0; c < 10; c++) step(4'b0000);
        step(4'b0100);
        checks++; if (phase !== 2'd2) begin fails++; $display("FAIL pulse_edge_phase: got %0d expected 2", phase); end
        step(4'b0000);
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL pulse_phase: got %0d expected 0", phase); end
        checks++; if (active_dir !== 2'd2) begin fails++; $display("FAIL pulse_dir: got %0d expected 2", active_dir); end
        checks++; if (light !== 12'h864) begin fails++; $display("FAIL pulse_light: got %h expected 864", light); end
        for (int c = 0; c < 10; c++) step(4'b0000);
    endtask

    task automatic test_two_dirs();
        int seg_ph[6]  = '{1, 2, 0, 1, 2, 0};
        int seg_len[6] = '{3, 2, 5, 3, 2, 8};
        int seg_dir[6] = '{2, 2, 3, 3, 3, 0};
        step(4'b1001);
        checks++; if (phase !== 2'd0) begin fails++; $display("FAIL two_edge_phase: got %0d expected 0", phase); end
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < seg_len[s]; c++) begin
                step(4'b0000);
                checks++; if (phase !== 2'(seg_ph[s]) || active_dir !== 2'(seg_dir[s])) begin
                    fails++; $display("FAIL two_seg%0d c%0d: got phase %0d dir %0d expected phase %0d dir %0d",
                                      s, c, phase, active_dir, seg_ph[s], seg_dir[s]);
                end
            end
        end
    endtask

    task automatic test_rest_green();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            step(4'b0010);
            if (c >= 1) begin
                checks++; if (phase !== 2'd0 || active_dir !== 2'd1) begin
                    fails++; $display("FAIL rest c%0d: got phase %0d dir %0d expected phase 0 dir 1", c, phase, active_dir);
                end
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        do_reset();
        step(4'b0001);
        step(4'b0000);
        step(4'b0010);
        for (int k = 0; k < 20 && phase !== 2'd1; k++) step(4'b0000);
        checks++; if (phase !== 2'd1) begin fails++; $display("FAIL myel_reach: got phase %0d expected 1", phase); end
        step(4'b0100);
        reset = 1'b1;
        #1;
        checks++; if (light !== 12'h924) begin fails++; $display("FAIL myel_light: got %h expected 924", light); end
        checks++; if (phase !== 2'd2) begin fails++; $display("FAIL myel_phase: got %0d expected 2", phase); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b0000);
            checks++; if (phase !== 2'd2) begin fails++; $display("FAIL myel_lost c%0d: got phase %0d expected 2", c, phase); end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_DIRS; i++) r[i] = ($urandom_range(0, 9) == 0);
            step(r);
            checks++; if (phase !== 2'(m_ph) || active_dir !== 2'(m_dir) || light !== m_light()) begin
                fails++; $display("FAIL random c%0d: got phase %0d dir %0d light %h expected phase %0d dir %0d light %h",
                                  c, phase, active_dir, light, m_ph, m_dir, m_light());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_pulse();
        test_two_dirs();
        test_rest_green();
        test_reset_mid_yellow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
